// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device transmitter for a PS/2 keyboard port.
// It sends one command byte (for example 0xED, set LEDs) using the PS/2
// request-to-send sequence:
//   1. Inhibit the bus by holding CLK low.
//   2. Pull DATA low as the start bit.
//   3. Release CLK.
//   4. Shift out the data bits, parity and stop on the device's falling
//      clock edges.
//   5. Check the device's ACK.
//   6. Wait for the bus to go idle.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   tx_data, tx_start byte to send; single-cycle request, accepted only when idle
//   ps2_clk_in/dat_in raw PS/2 pin levels (asynchronous)
//   ps2_clk_oe/dat_oe 1 = pull the line low, 0 = release it (open-drain)
//   busy              high whenever a frame is in progress
//   tx_done/tx_error  one-cycle completion pulses (ACKed / timeout or NACK)
module ps2_host_tx #(
    parameter int CLK_INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT      = 750000,
    parameter int PACKET_TIMEOUT     = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    localparam logic [19:0] INH_LAST   = 20'(CLK_INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] PKT_LAST   = 20'(PACKET_TIMEOUT - 1);

    state_t      state, state_nx;
    logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic        fall;
    logic [7:0]  byte_q, byte_nx;
    logic        par_q, par_nx;
    logic [3:0]  bit_q, bit_nx;
    logic [19:0] cnt, cnt_nx;
    logic        dat_oe_q, dat_oe_nx;
    logic        done_q, done_nx, err_q, err_nx;

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            // The synchronizers reset to the idle-bus level so that no false edge follows reset.
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            state    <= IDLE;
            byte_q   <= '0;
            par_q    <= 1'b0;
            bit_q    <= '0;
            cnt      <= '0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
            state    <= state_nx;
            byte_q   <= byte_nx;
            par_q    <= par_nx;
            bit_q    <= bit_nx;
            cnt      <= cnt_nx;
            dat_oe_q <= dat_oe_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
        end
    end

    // One saturating counter does two jobs:
    //   - it times the inhibit period;
    //   - from SEND entry onward it is the frame timeout.
    // It restarts at SEND entry and again at the first device falling edge.
    always_comb begin
        state_nx  = state;
        byte_nx   = byte_q;
        par_nx    = par_q;
        bit_nx    = bit_q;
        dat_oe_nx = dat_oe_q;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        cnt_nx    = (cnt == 20'hFFFFF) ? cnt : cnt + 20'd1;

        case (state)
            IDLE: begin
                dat_oe_nx = 1'b0;
                cnt_nx    = '0;
                if (tx_start) begin
                    byte_nx  = tx_data;
                    par_nx   = ~^tx_data;
                    bit_nx   = '0;
                    state_nx = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_nx  = REQ;
                    dat_oe_nx = 1'b1;       // start bit
                end
            end
            REQ: begin
                state_nx = SEND;
                cnt_nx   = '0;
            end
            SEND: begin
                if (fall) begin
                    if (bit_q == 4'd0) cnt_nx = '0;
                    bit_nx = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        dat_oe_nx = ~byte_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        dat_oe_nx = ~par_q;
                    end else begin
                        dat_oe_nx = 1'b0;   // stop bit: release DATA
                        state_nx  = ACK;
                    end
                end else if ((bit_q == 4'd0) ? (cnt >= START_LAST) : (cnt >= PKT_LAST)) begin
                    state_nx  = IDLE;
                    dat_oe_nx = 1'b0;
                    err_nx    = 1'b1;
                end
            end
            ACK: begin
                dat_oe_nx = 1'b0;
                if (fall) begin
                    if (dat_s2) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = WAIT_IDLE;
                    end
                end else if (cnt >= PKT_LAST) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (cnt >= PKT_LAST) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = (state != IDLE);
    assign tx_done    = done_q;
    assign tx_error   = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx.
// A behavioural PS/2 device clocks the open-drain bus and samples each bit
// while CLK is low. It optionally drives the ACK and checks the received
// bits against the frame expected for the byte.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int ST  = 300;
    localparam int PT  = 600;

    logic       clk = 1'b0;
    logic       reset, tx_start, dev_clk, dev_dat;
    logic [7:0] tx_data;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;

    int n_chk = 0, n_err = 0;
    int n_done = 0, n_txerr = 0, n_both = 0;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.CLK_INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .PACKET_TIMEOUT(PT)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_error) n_txerr++;
        if (tx_done && tx_error) n_both++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line order of the 10 bits after the start bit:
    //   data bits LSB first, then odd parity, then the stop bit (1).
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, ($countones(b) % 2 == 0), b};
    endfunction

    // Issue a request, then count inhibit cycles until the host releases CLK.
    // When poke is set, tx_start and tx_data are randomized while the host is busy.
    task automatic start_frame(input logic [7:0] b, input bit poke, output int cyc, output int first_dat);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        cyc       = 0;
        first_dat = 0;
        while (ps2_clk_oe && cyc < INH + 10) begin
            cyc++;
            if (ps2_dat_oe && first_dat == 0) first_dat = cyc;
            if (poke) begin
                tx_start = 1'($urandom_range(0, 1));
                tx_data  = 8'($urandom);
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input int h, input bit poke, input int rst_at);
        int cyc, first_dat, n, d0, e0;
        logic [9:0] got;
        got = '0;
        d0 = n_done;
        e0 = n_txerr;
        start_frame(b, poke, cyc, first_dat);
        chk("clk_oe_cycles", cyc, INH + 1);
        chk("dat_oe_first_cycle", first_dat, INH + 1);
        chk("start_bit_line", ps2_dat_in, 1'b0);
        wait_cyc(h);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) begin
                dev_dat = ack ? 1'b0 : 1'b1;
                wait_cyc(h);
            end
            dev_clk = 1'b0;
            if (i == 11 && !ack) begin
                // two synchronizer flops plus the registered pulse
                n = 0;
                while (!tx_error && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                chk("nack_latency", n, 3);
                chk("nack_busy", busy, 1'b0);
            end
            wait_cyc(h);
            if (i <= 10) got[i-1] = ps2_dat_in;
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_clk_oe", ps2_clk_oe, 1'b0);
                chk("rst_dat_oe", ps2_dat_oe, 1'b0);
                chk("rst_pulses", {tx_done, tx_error}, 2'b00);
                reset   = 1'b0;
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                wait_cyc(5);
                chk("rst_busy", busy, 1'b0);
                chk("rst_no_done", n_done, d0);
                chk("rst_no_error", n_txerr, e0);
                chk("rst_bits_so_far", got[4:0], frame_bits(b) & 10'h1F);
                return;
            end
            dev_clk = 1'b1;
            wait_cyc(h);
        end
        dev_dat = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        wait_cyc(2);
        chk("frame_busy_clear", busy, 1'b0);
        chk("frame_bits", got, frame_bits(b));
        chk("done_count", n_done, d0 + (ack ? 1 : 0));
        chk("error_count", n_txerr, e0 + (ack ? 0 : 1));
        chk("idle_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    endtask

    // The device never clocks: the host must give up exactly ST cycles after SEND entry.
    task automatic run_start_timeout();
        int cyc, first_dat, n;
        start_frame(8'($urandom), 1'b0, cyc, first_dat);
        n = 0;
        while (!tx_error && n < ST + 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout_cycles", n, ST);
        chk("start_timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("start_timeout_busy", busy, 1'b0);
        wait_cyc(3);
    endtask

    // The device clocks once, then holds CLK low: the packet timeout must fire.
    task automatic run_pkt_timeout();
        int cyc, first_dat, n, d0;
        d0 = n_done;
        start_frame(8'($urandom), 1'b0, cyc, first_dat);
        wait_cyc(8);
        dev_clk = 1'b0;
        n = 0;
        while (!tx_error && n < PT + 20) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_timeout_window", (n >= PT && n <= PT + 4), 1'b1);
        chk("pkt_timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        dev_clk = 1'b1;
        wait_cyc(5);
        chk("pkt_timeout_no_done", n_done, d0);
    endtask

    initial begin
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        wait_cyc(3);
        chk("reset_clk_oe", ps2_clk_oe, 1'b0);
        chk("reset_dat_oe", ps2_dat_oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_pulses", {tx_done, tx_error}, 2'b00);
        reset = 1'b0;
        wait_cyc(3);
        chk("post_reset_no_pulse", n_done + n_txerr, 0);

        run_frame(8'hED, 1'b1, 8, 1'b0, -1);
        run_frame(8'h00, 1'b1, 8, 1'b0, -1);
        run_frame(8'hA5, 1'b0, 7, 1'b0, -1);
        run_start_timeout();
        run_pkt_timeout();
        run_frame(8'h3C, 1'b1, 6, 1'b1, -1);
        run_frame(8'h2B, 1'b1, 8, 1'b1, 5);
        for (int k = 0; k < 8; k++)
            run_frame(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(5, 12),
                      1'($urandom_range(0, 1)), -1);
        run_frame(8'hFF, 1'b1, 9, 1'b0, -1);

        chk("never_done_and_error", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_INHIBIT_CYCLES, default 5000, clock-low inhibit time (100 us at 50 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, default 750000, max cycles from SEND entry to first device falling edge (15 ms).
REQ-003 SHALL have parameter PACKET_TIMEOUT, default 100000, max cycles from first falling edge to bus-idle (2 ms).
REQ-004 SHALL have port clk  input  1  system clock (CLOCK_50); one clock only, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_data  input  8  command byte to send to the keyboard (e.g. 0xED set-LEDs).
REQ-007 SHALL have port tx_start  input  1  single-cycle request; accepted only in IDLE.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS2_CLK pin level (asynchronous).
REQ-009 SHALL have port ps2_dat_in  input  1  raw PS2_DAT pin level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = pull PS2_CLK low, 0 = release (open-drain, top level drives 1'b0 or 1'bz).
REQ-011 SHALL have port ps2_dat_oe  output  1  1 = pull PS2_DAT low, 0 = release.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE; top level gates lbkeyboard2 with it.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse on ACKed completion.
REQ-014 SHALL have port tx_error  output  1  one-cycle pulse on timeout or missing ACK.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_dat_in through two-flop synchronizers; falling edge = previous synced clk 1, current 0.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe 0; tx_start=1 latches tx_data, computes odd parity (~^tx_data), clears counters, enters INHIBIT next cycle.
REQ-018 INHIBIT: clk_oe=1, dat_oe=0 for exactly CLK_INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: clk_oe=1, dat_oe=1 for exactly one cycle, then SEND.
REQ-020 SEND: clk_oe=0; dat_oe=1 (start bit) until first falling edge; bit index k counts falling edges from 0.
REQ-021 SEND: on falling edge k=0..7 dat_oe<=~tx_data[k] (LSB first); k=8 dat_oe<=~parity; k=9 dat_oe<=0 (stop) and enter ACK.
REQ-022 ACK: dat_oe=0; on next falling edge sample synced data: 0 -> WAIT_IDLE, 1 -> tx_error pulse, IDLE.
REQ-023 WAIT_IDLE: on synced clk=1 and data=1, pulse tx_done and enter IDLE.
REQ-024 SHALL update dat_oe exactly one cycle after the falling edge is detected.
REQ-025 Timeout: if no falling edge within START_TIMEOUT cycles of SEND entry, or WAIT_IDLE not exited within PACKET_TIMEOUT cycles of first falling edge, release both lines, pulse tx_error, enter IDLE.
REQ-026 Timeout counter SHALL be 20 bits, saturating, reset on SEND entry and on first falling edge; parameters above 2^20-1 are illegal.
REQ-027 tx_start while busy=1 SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-028 tx_done and tx_error SHALL never assert in the same cycle; each frame ends in exactly one of them.
REQ-029 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored.

Reset
REQ-030 reset=1 SHALL force IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, tx_done=0, tx_error=0, counters 0, on the next rising edge.
REQ-031 reset mid-frame SHALL release both lines the following cycle with no tx_done or tx_error pulse.
REQ-032 Synchronizer flops SHALL reset to 1 (idle bus) so no false edge follows reset.

Verification
REQ-033 tx_data=0xED, device model clocks at 12.5 kHz and ACKs -> clk_oe high cycles 1..5001, dat_oe high cycles 5001..first edge, data bits on line 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK 0, one tx_done, no tx_error.
REQ-034 tx_data=0x00 -> dat_oe=1 for all eight data bits, parity line 1 (dat_oe=0), tx_done pulse.
REQ-035 Device leaves DATA high at 11th falling edge -> tx_error pulse one cycle later, busy=0, no tx_done.
REQ-036 Device never clocks -> tx_error exactly START_TIMEOUT cycles after SEND entry, both oe 0.
REQ-037 tx_start repeated during INHIBIT with different tx_data -> ignored, original byte sent; reset at bit 4 -> oe both 0 next cycle, no pulses.
